// File: rtl/fft_pkg.sv
// Shared constants and state encodings for the FFT input framer.
package fft_pkg;

    localparam int unsigned I_WIDTH     = 13;
    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned FRAME_BEATS = 32;
    localparam int unsigned FRAME_GAP   = 4;

    localparam int unsigned IDX_W = $clog2(FRAME_BEATS);
    // Gap counter also spans the cycle the final beat occupies the bus.
    localparam int unsigned GAP_W = $clog2(FRAME_GAP + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of beat storage: synchronous write, combinational indexed read.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic signed [I_WIDTH-1:0] wr_re [0:DATA_WIDTH-1],
    input  logic signed [I_WIDTH-1:0] wr_im [0:DATA_WIDTH-1],
    input  logic [IDX_W-1:0]          rd_idx,
    output logic signed [I_WIDTH-1:0] rd_re_c [0:DATA_WIDTH-1],
    output logic signed [I_WIDTH-1:0] rd_im_c [0:DATA_WIDTH-1]
);

    logic signed [I_WIDTH-1:0] mem_re [0:FRAME_BEATS-1][0:DATA_WIDTH-1];
    logic signed [I_WIDTH-1:0] mem_im [0:FRAME_BEATS-1][0:DATA_WIDTH-1];

    // Store an accepted beat at its frame position.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < DATA_WIDTH; l++) begin
                mem_re[wr_idx][l] <= wr_re[l];
                mem_im[wr_idx][l] <= wr_im[l];
            end
        end
    end

    // Present the addressed beat.
    always_comb begin
        for (int l = 0; l < DATA_WIDTH; l++) begin
            rd_re_c[l] = mem_re[rd_idx][l];
            rd_im_c[l] = mem_im[rd_idx][l];
        end
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Ping-pong input framer for the 512-point FFT: collects bursty beats into
// two frame banks and replays each frame as 32 contiguous beats followed by
// an idle gap. Optional framing check (in_last validation, frame_err) is
// enabled with `define FFT_FEEDER_FRAME_CHECK_EN.
module fft_frame_feeder
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [I_WIDTH-1:0] in_re [0:DATA_WIDTH-1],
    input  logic signed [I_WIDTH-1:0] in_im [0:DATA_WIDTH-1],
    input  logic                      in_last,
    output logic signed [I_WIDTH-1:0] dout_re [0:DATA_WIDTH-1],
    output logic signed [I_WIDTH-1:0] dout_im [0:DATA_WIDTH-1],
    output logic                      valid_0_2,
    output logic                      frame_start,
    output logic                      frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BEATS - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(FRAME_GAP);

    bank_state_t bank_st  [2];
    bank_state_t bank_nxt [2];

    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;

    rd_state_t        rd_state, rd_state_nxt;
    logic             rd_bank, rd_bank_nxt;
    logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [IDX_W-1:0] rd_addr_c;

    logic accept_c, wr_last_c, drop_c, err_c;
    logic load_c, start_c, release_c;

    logic signed [I_WIDTH-1:0] b0_re_c [0:DATA_WIDTH-1];
    logic signed [I_WIDTH-1:0] b0_im_c [0:DATA_WIDTH-1];
    logic signed [I_WIDTH-1:0] b1_re_c [0:DATA_WIDTH-1];
    logic signed [I_WIDTH-1:0] b1_im_c [0:DATA_WIDTH-1];
    logic signed [I_WIDTH-1:0] rd_re_c [0:DATA_WIDTH-1];
    logic signed [I_WIDTH-1:0] rd_im_c [0:DATA_WIDTH-1];

    assign in_ready  = (bank_st[wr_bank] != FULL);
    assign accept_c  = in_valid && in_ready;
    assign wr_last_c = (wr_idx == LAST_IDX);

`ifdef FFT_FEEDER_FRAME_CHECK_EN
    // Early last drops the partial frame; a missing last still commits it.
    assign drop_c = accept_c && in_last && !wr_last_c;
    assign err_c  = drop_c || (accept_c && wr_last_c && !in_last);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign drop_c = 1'b0;
    assign err_c  = 1'b0;
`endif

    fft_frame_bank u_bank0 (
        .clk    (clk),
        .wr_en  (accept_c && (wr_bank == 1'b0)),
        .wr_idx (wr_idx),
        .wr_re  (in_re),
        .wr_im  (in_im),
        .rd_idx (rd_addr_c),
        .rd_re_c(b0_re_c),
        .rd_im_c(b0_im_c)
    );

    fft_frame_bank u_bank1 (
        .clk    (clk),
        .wr_en  (accept_c && (wr_bank == 1'b1)),
        .wr_idx (wr_idx),
        .wr_re  (in_re),
        .wr_im  (in_im),
        .rd_idx (rd_addr_c),
        .rd_re_c(b1_re_c),
        .rd_im_c(b1_im_c)
    );

    // Select the bank being replayed.
    always_comb begin
        for (int l = 0; l < DATA_WIDTH; l++) begin
            rd_re_c[l] = rd_bank ? b1_re_c[l] : b0_re_c[l];
            rd_im_c[l] = rd_bank ? b1_im_c[l] : b0_im_c[l];
        end
    end

    // Bank occupancy: write and read sides touch different banks.
    always_comb begin
        bank_nxt[0] = bank_st[0];
        bank_nxt[1] = bank_st[1];
        if (accept_c) begin
            if (wr_last_c) begin
                bank_nxt[wr_bank] = FULL;
            end else if (drop_c) begin
                bank_nxt[wr_bank] = EMPTY;
            end else begin
                bank_nxt[wr_bank] = FILLING;
            end
        end
        if (release_c) begin
            bank_nxt[rd_bank] = EMPTY;
        end
    end

    // Write position and bank state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
        end else begin
            bank_st[0] <= bank_nxt[0];
            bank_st[1] <= bank_nxt[1];
            if (accept_c) begin
                if (wr_last_c) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else if (drop_c) begin
                    wr_idx  <= '0;
                end else begin
                    wr_idx  <= wr_idx + 1'b1;
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state <= IDLE;
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            gap_cnt  <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            rd_bank  <= rd_bank_nxt;
            rd_idx   <= rd_idx_nxt;
            gap_cnt  <= gap_nxt;
        end
    end

    // Read FSM: load_c registers the addressed beat onto dout this edge.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_bank_nxt  = rd_bank;
        rd_idx_nxt   = rd_idx;
        gap_nxt      = gap_cnt;
        load_c       = 1'b0;
        start_c      = 1'b0;
        release_c    = 1'b0;
        case (rd_state)
            IDLE: begin
                if (bank_st[rd_bank] == FULL) begin
                    load_c       = 1'b1;
                    start_c      = 1'b1;
                    rd_idx_nxt   = IDX_W'(1);
                    rd_state_nxt = BURST;
                end
            end
            BURST: begin
                load_c     = 1'b1;
                rd_idx_nxt = rd_idx + 1'b1;
                if (rd_idx == LAST_IDX) begin
                    release_c    = 1'b1;
                    rd_bank_nxt  = ~rd_bank;
                    rd_idx_nxt   = '0;
                    gap_nxt      = '0;
                    rd_state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_END) begin
                    if (bank_st[rd_bank] == FULL) begin
                        load_c       = 1'b1;
                        start_c      = 1'b1;
                        rd_idx_nxt   = IDX_W'(1);
                        rd_state_nxt = BURST;
                    end else begin
                        rd_state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                rd_state_nxt = IDLE;
            end
        endcase
    end

    assign rd_addr_c = (rd_state == BURST) ? rd_idx : '0;

    // Registered butterfly-side outputs; dout holds between bursts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_0_2   <= 1'b0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            for (int l = 0; l < DATA_WIDTH; l++) begin
                dout_re[l] <= '0;
                dout_im[l] <= '0;
            end
        end else begin
            valid_0_2   <= load_c;
            frame_start <= start_c;
            frame_err   <= err_c;
            if (load_c) begin
                for (int l = 0; l < DATA_WIDTH; l++) begin
                    dout_re[l] <= rd_re_c[l];
                    dout_im[l] <= rd_im_c[l];
                end
            end
        end
    end

endmodule
